// File: rtl/gc_loader_pkg.sv
// Shared types, header indices and field helpers for the netlist loader.
// Header words pack two size fields: hi = [2P-1:P], lo = [P-1:0].
package gc_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_HDR   = 3'd2,
    S_BODY  = 3'd3,
    S_RUN   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam int HDR_INIT     = 0;
  localparam int HDR_INPUT    = 1;
  localparam int HDR_OUT_DFF  = 2;
  localparam int HDR_GATE_XOR = 3;
  localparam int HDR_WORDS    = 4;

  function automatic logic [31:0] fld_lo(
    input logic [31:0] w,
    input int          p
  );
    return w & ((32'd1 << p) - 32'd1);
  endfunction

  function automatic logic [31:0] fld_hi(
    input logic [31:0] w,
    input int          p
  );
    return (w >> p) & ((32'd1 << p) - 32'd1);
  endfunction

  function automatic logic [31:0] fld_sum(
    input logic [31:0] w,
    input int          p
  );
    return fld_lo(w, p) + fld_hi(w, p);
  endfunction

endpackage

// File: rtl/gc_netlist_loader_prefetch.sv
// gc_rom_prefetch: 2-entry skid buffer over a 1-cycle-latency ROM.
// Ports: load/base start a burst, stop halts issue, out_* is the stream.
module gc_rom_prefetch #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] base,
  input  logic              stop,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic              out_valid,
  output logic [31:0]       out_word,
  input  logic              out_ready
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              vld_q, vld_d;
  logic [31:0]       mem_q [2];
  logic [31:0]       mem_d [2];
  logic [1:0]        cnt_q, cnt_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              pop, pop_fifo, push;

  always_comb begin
    out_valid = (cnt_q != 2'd0) || vld_q;
    out_word  = (cnt_q != 2'd0) ? mem_q[rd_q] : rom_data;
    pop       = out_valid && out_ready;
    pop_fifo  = pop && (cnt_q != 2'd0);
    // ROM data bypasses the buffer when it is empty and consumed
    push      = vld_q && !(pop && cnt_q == 2'd0);
    cnt_d     = cnt_q + {1'b0, push} - {1'b0, pop_fifo};
    rd_d      = rd_q ^ pop_fifo;
    wr_d      = wr_q ^ push;
    mem_d     = mem_q;
    if (push) mem_d[wr_q] = rom_data;
    // issue only if the word returning next cycle has a slot
    rom_en    = load || (!stop && cnt_d < 2'd2);
    rom_addr  = load ? base : addr_q;
    addr_d    = rom_en ? rom_addr + ADDR_W'(1) : addr_q;
    vld_d     = rom_en;
    if (load) begin
      cnt_d = 2'd0;
      rd_d  = 1'b0;
      wr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      vld_q  <= 1'b0;
      mem_q  <= '{default: '0};
      cnt_q  <= 2'd0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
    end else begin
      addr_q <= addr_d;
      vld_q  <= vld_d;
      mem_q  <= mem_d;
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
    end
  end

endmodule

// File: rtl/gc_netlist_loader.sv
// Fetches a netlist image from ROM, streams it to the GC core, waits done.
// Ports: go/base_addr/num_cc in, rom_*, gc_*, status + parsed header out.
// Optional header/range check: define GC_LOADER_CHECK_EN.
module gc_netlist_loader
  import gc_loader_pkg::*;
#(
  parameter int P      = 16,
  parameter int ADDR_W = 16,
  parameter int CID_W  = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CID_W-1:0]  num_cc,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic              gc_start,
  output logic [31:0]       gc_netlist_in,
  input  logic [CID_W-1:0]  gc_cid,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [P:0]        init_size,
  output logic [P:0]        input_size,
  output logic [P-1:0]      output_size,
  output logic [P-1:0]      dff_size,
  output logic [P-1:0]      gate_size,
  output logic [P-1:0]      num_xor,
  output logic [CNT_W-1:0]  run_cycles
);

  localparam int CW = P + 2;
  localparam logic [CW-1:0] HW = CW'(HDR_WORDS);

  state_t            state_q, state_d;
  logic [CID_W-1:0]  ncc_q, ncc_d;
  logic [CW-1:0]     iss_q, iss_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     tot_q, tot_d;
  logic              known_q, known_d;
  logic              bad_q, bad_d;
  logic [P-1:0]      dffp_q, dffp_d;
  logic [31:0]       netl_q, netl_d;
  logic [P:0]        init_q, init_d;
  logic [P:0]        inp_q, inp_d;
  logic [P-1:0]      outs_q, outs_d;
  logic [P-1:0]      dff_q, dff_d;
  logic [P-1:0]      gate_q, gate_d;
  logic [P-1:0]      xor_q, xor_d;
  logic [CNT_W-1:0]  run_q, run_d;

  logic              accept, streaming, hdr3, bad_now;
  logic [P:0]        len_now;
  logic [CW-1:0]     tot_now, lim;
  logic              pf_stop, pf_valid;
  logic [31:0]       pf_word;

`ifdef GC_LOADER_CHECK_EN
  localparam int SW = ((ADDR_W > P) ? ADDR_W : P) + 3;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              err_q, err_d;
  logic [SW-1:0]     end_addr;
`endif

  gc_rom_prefetch #(.ADDR_W(ADDR_W)) u_pf (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .base      (base_addr),
    .stop      (pf_stop),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_valid (pf_valid),
    .out_word  (pf_word),
    .out_ready (1'b1)
  );

  // Body length is decoded from word 3 as it leaves the ROM, so
  // the issue limit is known before any read past the body.
  always_comb begin
    accept    = (state_q == S_IDLE) && go;
    streaming = (state_q == S_START) || (state_q == S_HDR) ||
                (state_q == S_BODY);
    hdr3      = pf_valid && (idx_q == CW'(HDR_GATE_XOR));
    len_now   = (P+1)'(fld_lo(pf_word, P)) + (P+1)'(dffp_q);
`ifdef GC_LOADER_CHECK_EN
    end_addr  = SW'(base_q) + SW'(HW) + SW'(len_now);
    bad_now   = (fld_hi(pf_word, P) > fld_lo(pf_word, P)) ||
                (end_addr > (SW'(1) << ADDR_W));
`else
    bad_now   = 1'b0;
`endif
    tot_now   = bad_now ? HW : HW + CW'(len_now);
    if (hdr3)         lim = tot_now;
    else if (known_q) lim = tot_q;
    else              lim = HW;
    pf_stop   = !streaming || (iss_q >= lim);
  end

  always_comb begin
    state_d = state_q;
    ncc_d   = ncc_q;
    tot_d   = tot_q;
    known_d = known_q;
    bad_d   = bad_q;
    dffp_d  = dffp_q;
    init_d  = init_q;
    inp_d   = inp_q;
    outs_d  = outs_q;
    dff_d   = dff_q;
    gate_d  = gate_q;
    xor_d   = xor_q;
    run_d   = run_q;
    iss_d   = (accept ? '0 : iss_q) + CW'(rom_en);
    idx_d   = (accept ? '0 : idx_q) + CW'(pf_valid);
    netl_d  = pf_valid ? pf_word : 32'd0;
`ifdef GC_LOADER_CHECK_EN
    base_d  = base_q;
    err_d   = err_q;
`endif
    if (pf_valid && idx_q == CW'(HDR_OUT_DFF))
      dffp_d = P'(fld_hi(pf_word, P));
    if (hdr3) begin
      known_d = 1'b1;
      tot_d   = tot_now;
      bad_d   = bad_now;
    end
    // idx_q = i+1 while header word i sits on gc_netlist_in
    if (state_q == S_HDR) begin
      unique case (1'b1)
        idx_q == CW'(HDR_INIT + 1):
          init_d = (P+1)'(fld_sum(netl_q, P));
        idx_q == CW'(HDR_INPUT + 1):
          inp_d = (P+1)'(fld_sum(netl_q, P));
        idx_q == CW'(HDR_OUT_DFF + 1): begin
          outs_d = P'(fld_lo(netl_q, P));
          dff_d  = P'(fld_hi(netl_q, P));
        end
        idx_q == CW'(HDR_GATE_XOR + 1): begin
          gate_d = P'(fld_lo(netl_q, P));
          xor_d  = P'(fld_hi(netl_q, P));
        end
        default: ;
      endcase
    end
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          ncc_d   = num_cc;
          known_d = 1'b0;
          bad_d   = 1'b0;
          run_d   = '0;
`ifdef GC_LOADER_CHECK_EN
          base_d  = base_addr;
          err_d   = 1'b0;
`endif
        end
      end
      S_START: state_d = S_HDR;
      S_HDR: begin
        if (idx_q == HW) begin
          if (bad_q) begin
            state_d = S_DONE;
`ifdef GC_LOADER_CHECK_EN
            err_d   = 1'b1;
`endif
          end else if (tot_q == HW) begin
            state_d = S_RUN;
          end else begin
            state_d = S_BODY;
          end
        end
      end
      S_BODY: if (idx_q == tot_q) state_d = S_RUN;
      S_RUN: begin
        if (run_q != '1) run_d = run_q + CNT_W'(1);
        if (ncc_q == '0 || gc_cid == ncc_q) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ncc_q   <= '0;
      iss_q   <= '0;
      idx_q   <= '0;
      tot_q   <= '0;
      known_q <= 1'b0;
      bad_q   <= 1'b0;
      dffp_q  <= '0;
      netl_q  <= '0;
      init_q  <= '0;
      inp_q   <= '0;
      outs_q  <= '0;
      dff_q   <= '0;
      gate_q  <= '0;
      xor_q   <= '0;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      ncc_q   <= ncc_d;
      iss_q   <= iss_d;
      idx_q   <= idx_d;
      tot_q   <= tot_d;
      known_q <= known_d;
      bad_q   <= bad_d;
      dffp_q  <= dffp_d;
      netl_q  <= netl_d;
      init_q  <= init_d;
      inp_q   <= inp_d;
      outs_q  <= outs_d;
      dff_q   <= dff_d;
      gate_q  <= gate_d;
      xor_q   <= xor_d;
      run_q   <= run_d;
    end
  end

`ifdef GC_LOADER_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q <= '0;
      err_q  <= 1'b0;
    end else begin
      base_q <= base_d;
      err_q  <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign gc_start      = (state_q == S_START);
  assign busy          = (state_q == S_START) || (state_q == S_HDR) ||
                         (state_q == S_BODY) || (state_q == S_RUN);
  assign done          = (state_q == S_DONE);
  assign gc_netlist_in = netl_q;
  assign init_size     = init_q;
  assign input_size    = inp_q;
  assign output_size   = outs_q;
  assign dff_size      = dff_q;
  assign gate_size     = gate_q;
  assign num_xor       = xor_q;
  assign run_cycles    = run_q;

endmodule

// File: tb/tb_gc_netlist_loader.sv
// Directed bench for gc_netlist_loader with a behavioural sync ROM.
// Inputs change #1 after posedge; outputs are sampled on negedge.
module tb_gc_netlist_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] num_cc = '0;
  logic [15:0] gc_cid = '0;
  logic        rom_en;
  logic [15:0] rom_addr;
  logic [31:0] rom_data = '0;
  logic        gc_start;
  logic [31:0] gc_netlist_in;
  logic        busy, done, err;
  logic [16:0] init_size, input_size;
  logic [15:0] output_size, dff_size, gate_size, num_xor;
  logic [31:0] run_cycles;

  logic [31:0] rom [0:65535];
  logic [15:0] alog [$];
  logic [31:0] img1 [15];
  int n_tests = 0;
  int n_fail = 0;
  logic seen;

  gc_netlist_loader dut (
    .clk(clk), .rst(rst), .go(go), .base_addr(base_addr),
    .num_cc(num_cc), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .gc_start(gc_start),
    .gc_netlist_in(gc_netlist_in), .gc_cid(gc_cid),
    .busy(busy), .done(done), .err(err),
    .init_size(init_size), .input_size(input_size),
    .output_size(output_size), .dff_size(dff_size),
    .gate_size(gate_size), .num_xor(num_xor),
    .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_en) begin
      rom_data <= rom[rom_addr];
      alog.push_back(rom_addr);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      cyc();
      neg();
      if (done) seen = 1'b1;
    end
    chk(tag, seen, 1'b1);
    cyc();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) rom[i] = 32'hDEAD_0000 | i;
    img1[0] = 32'h0002_0003;
    img1[1] = 32'h0004_0000;
    img1[2] = 32'h0001_0008;
    img1[3] = 32'h0006_000A;
    for (int k = 0; k < 11; k++) img1[4+k] = 32'hB000_0000 + k;
    for (int k = 0; k < 15; k++) rom[16'h0100 + k] = img1[k];
    rom[16'h0200] = 32'h0002_0003;
    rom[16'h0201] = 32'h0004_0000;
    rom[16'h0202] = 32'h0000_0008;
    rom[16'h0203] = 32'h0000_0000;
    rom[16'h0300] = 32'h0002_0003;
    rom[16'h0301] = 32'h0004_0000;
    rom[16'h0302] = 32'h0001_0008;
    rom[16'h0303] = 32'h000B_000A;
    rom[16'hFFFE] = 32'h0002_0003;
    rom[16'hFFFF] = 32'h0004_0000;
    rom[16'h0000] = 32'h0001_0008;
    rom[16'h0001] = 32'h0000_0001;
    rom[16'h0002] = 32'hC000_0000;
    rom[16'h0003] = 32'hC000_0001;

    // reset state
    cyc();
    cyc();
    neg();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_start", gc_start, 0);
    chk("rst_netl", gc_netlist_in, 0);
    chk("rst_err", err, 0);
    chk("rst_run", run_cycles, 0);
    chk("rst_init", init_size, 0);
    chk("rst_rom_en", rom_en, 0);
    cyc();
    rst = 1'b0;
    cyc();

    // test 1: 11-word body, num_cc = 3, 40 RUN cycles
    alog.delete();
    base_addr = 16'h0100;
    num_cc = 16'd3;
    gc_cid = 16'd0;
    go = 1'b1;
    neg();
    chk("t1_rom_en_T", rom_en, 1);
    chk("t1_rom_addr_T", rom_addr, 16'h0100);
    chk("t1_start_T", gc_start, 0);
    cyc();
    go = 1'b0;
    neg();
    chk("t1_start_T1", gc_start, 1);
    chk("t1_busy_T1", busy, 1);
    chk("t1_netl_T1", gc_netlist_in, 0);
    for (int i = 0; i < 15; i++) begin
      cyc();
      neg();
      chk($sformatf("t1_word%0d", i), gc_netlist_in, img1[i]);
      if (i == 1) begin
        chk("t1_init_early", init_size, 5);
        chk("t1_start_low", gc_start, 0);
      end
    end
    cyc();
    neg();
    chk("t1_netl_zero", gc_netlist_in, 0);
    chk("t1_init", init_size, 5);
    chk("t1_input", input_size, 4);
    chk("t1_output", output_size, 8);
    chk("t1_dff", dff_size, 1);
    chk("t1_gate", gate_size, 10);
    chk("t1_xor", num_xor, 6);
    chk("t1_busy_run", busy, 1);
    for (int c = 2; c <= 40; c++) begin
      cyc();
      if (c == 14) gc_cid = 16'd1;
      if (c == 27) gc_cid = 16'd2;
      if (c == 40) gc_cid = 16'd3;
    end
    neg();
    chk("t1_done_early", done, 0);
    cyc();
    neg();
    chk("t1_done", done, 1);
    chk("t1_busy_done", busy, 0);
    chk("t1_err", err, 0);
    cyc();
    gc_cid = 16'd0;
    neg();
    chk("t1_done_pulse", done, 0);
    chk("t1_run_cycles", run_cycles, 40);
    chk("t1_reads", alog.size(), 15);
    chk("t1_last_addr", alog[alog.size()-1], 16'h010E);

    // test 2: empty body, num_cc = 0
    cyc();
    alog.delete();
    base_addr = 16'h0200;
    num_cc = 16'd0;
    go = 1'b1;
    cyc();
    go = 1'b0;
    neg();
    chk("t2_start", gc_start, 1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      neg();
      chk($sformatf("t2_word%0d", i), gc_netlist_in,
          rom[16'h0200 + i]);
    end
    cyc();
    neg();
    chk("t2_netl_zero", gc_netlist_in, 0);
    chk("t2_busy_run", busy, 1);
    chk("t2_no_done_yet", done, 0);
    chk("t2_dff", dff_size, 0);
    chk("t2_gate", gate_size, 0);
    cyc();
    neg();
    chk("t2_done", done, 1);
    cyc();
    neg();
    chk("t2_done_pulse", done, 0);
    chk("t2_run_cycles", run_cycles, 1);
    chk("t2_reads", alog.size(), 4);

    // test 3: go during BODY ignored, rst at word 7 aborts
    cyc();
    base_addr = 16'h0100;
    num_cc = 16'd3;
    go = 1'b1;
    cyc();
    go = 1'b0;
    for (int k = 0; k < 5; k++) cyc();
    cyc();
    go = 1'b1;
    base_addr = 16'h0200;
    neg();
    chk("t3_word5", gc_netlist_in, img1[5]);
    cyc();
    go = 1'b0;
    neg();
    chk("t3_no_restart", gc_start, 0);
    chk("t3_word6", gc_netlist_in, img1[6]);
    chk("t3_busy", busy, 1);
    cyc();
    rst = 1'b1;
    neg();
    chk("t3_word7", gc_netlist_in, img1[7]);
    cyc();
    rst = 1'b0;
    neg();
    chk("t3_busy_rst", busy, 0);
    chk("t3_netl_rst", gc_netlist_in, 0);
    chk("t3_start_rst", gc_start, 0);
    chk("t3_done_rst", done, 0);
    chk("t3_run_rst", run_cycles, 0);
    chk("t3_init_rst", init_size, 0);
    chk("t3_gate_rst", gate_size, 0);
    chk("t3_rom_en_rst", rom_en, 0);
    cyc();
    base_addr = 16'h0200;
    num_cc = 16'd0;
    go = 1'b1;
    neg();
    chk("t3_re_addr", rom_addr, 16'h0200);
    cyc();
    go = 1'b0;
    neg();
    chk("t3_re_start", gc_start, 1);
    cyc();
    neg();
    chk("t3_re_word0", gc_netlist_in, 32'h0002_0003);
    wait_done("t3_re_done");

`ifdef GC_LOADER_CHECK_EN
    // test 4: num_xor > gate_size flags err, no body
    alog.delete();
    base_addr = 16'h0300;
    num_cc = 16'd3;
    go = 1'b1;
    cyc();
    go = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      neg();
      chk($sformatf("t4_word%0d", i), gc_netlist_in,
          rom[16'h0300 + i]);
    end
    cyc();
    neg();
    chk("t4_done", done, 1);
    chk("t4_err", err, 1);
    chk("t4_netl_zero", gc_netlist_in, 0);
    chk("t4_xor", num_xor, 11);
    cyc();
    neg();
    chk("t4_err_sticky", err, 1);
    chk("t4_run_zero", run_cycles, 0);
    chk("t4_netl_zero2", gc_netlist_in, 0);
    chk("t4_reads", alog.size(), 4);
    base_addr = 16'h0200;
    num_cc = 16'd0;
    cyc();
    go = 1'b1;
    cyc();
    go = 1'b0;
    neg();
    chk("t4_err_clear", err, 0);
    wait_done("t4_re_done");
`else
    // test 5: address wrap
    alog.delete();
    base_addr = 16'hFFFE;
    num_cc = 16'd0;
    go = 1'b1;
    cyc();
    go = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      neg();
      chk($sformatf("t5_word%0d", i), gc_netlist_in,
          rom[16'(16'hFFFE + i)]);
    end
    cyc();
    neg();
    chk("t5_netl_zero", gc_netlist_in, 0);
    chk("t5_err", err, 0);
    wait_done("t5_done");
    chk("t5_reads", alog.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < alog.size())
        chk($sformatf("t5_addr%0d", i), alog[i],
            16'(16'hFFFE + i));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
